// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / branch-resolution stage.
// Branch funct3 encodings, FSM state type and datapath width.
package pc_ctrl_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN,
        ST_TRAP
    } pc_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluation from funct3 and the comparator flags.
// Also selects the comparator signedness, which depends only on funct3[1].
module br_cond_eval
    import pc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       cond,
    output logic       br_un
);

    assign br_un = funct3[1];

    // The comparator already applied the signedness, so BLT/BLTU share logic.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = equal;
            F3_BNE:  cond = ~equal;
            F3_BLT:  cond = less;
            F3_BGE:  cond = ~less;
            F3_BLTU: cond = less;
            F3_BGEU: cond = ~less;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register, branch/jump target selection, misaligned-target trap FSM
// and branch performance counters for the single-cycle RV32I core.
//
// state   | meaning
// ST_RUN  | executing; PC advances on valid, unstalled instructions
// ST_TRAP | misaligned target trapped; everything holds until i_trap_ack
module pc_branch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [RV_XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [RV_XLEN-1:0] TRAP_PC  = 32'h0000_0100,
    parameter int                 CNT_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_instr_valid,
    input  logic               i_stall,
    input  logic               i_is_branch,
    input  logic               i_is_jal,
    input  logic               i_is_jalr,
    input  logic [2:0]         i_funct3,
    input  logic [RV_XLEN-1:0] i_imm,
    input  logic [RV_XLEN-1:0] i_rs1_data,
    input  logic               i_br_less,
    input  logic               i_br_equal,
    input  logic               i_trap_ack,
    output logic               o_br_un,
    output logic [RV_XLEN-1:0] o_pc,
    output logic [RV_XLEN-1:0] o_pc_plus4,
    output logic               o_taken,
    output logic               o_trap,
    output logic [RV_XLEN-1:0] o_trap_epc,
    output logic [CNT_W-1:0]   o_br_cnt,
    output logic [CNT_W-1:0]   o_taken_cnt
);

    pc_state_e          state;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] trap_epc;
    logic               trap;
    logic [CNT_W-1:0]   br_cnt;
    logic [CNT_W-1:0]   taken_cnt;

    logic               cond;
    logic               br_un;
    logic               is_cond_br;
    logic               redirect;
    logic               update;
    logic               misaligned;
    logic [RV_XLEN-1:0] pc_plus4;
    logic [RV_XLEN-1:0] target;

    br_cond_eval u_br_cond_eval (
        .funct3 (i_funct3),
        .less   (i_br_less),
        .equal  (i_br_equal),
        .cond   (cond),
        .br_un  (br_un)
    );

    // A jump asserted alongside a branch wins, so the branch is not counted.
    assign is_cond_br = i_is_branch & ~i_is_jal & ~i_is_jalr;

    assign pc_plus4 = pc + RV_XLEN'(4);
    assign target   = i_is_jalr ? ((i_rs1_data + i_imm) & ~RV_XLEN'(1))
                                : (pc + i_imm);

    assign redirect   = (state == ST_RUN)
                      & (i_is_jal | i_is_jalr | (i_is_branch & cond));
    assign update     = (state == ST_RUN) & i_instr_valid & ~i_stall;
    assign misaligned = redirect & (target[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            trap      <= 1'b0;
            trap_epc  <= '0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (update) begin
                        if (is_cond_br) begin
                            br_cnt <= br_cnt + CNT_W'(1);
                            if (cond) begin
                                taken_cnt <= taken_cnt + CNT_W'(1);
                            end
                        end
                        if (misaligned) begin
                            trap_epc <= pc;
                            pc       <= TRAP_PC;
                            state    <= ST_TRAP;
                            trap     <= 1'b1;
                        end else if (redirect) begin
                            pc <= target;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                ST_TRAP: begin
                    if (i_trap_ack) begin
                        state <= ST_RUN;
                        trap  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    trap  <= 1'b0;
                end
            endcase
        end
    end

    assign o_br_un     = br_un;
    assign o_pc        = pc;
    assign o_pc_plus4  = pc_plus4;
    assign o_taken     = redirect;
    assign o_trap      = trap;
    assign o_trap_epc  = trap_epc;
    assign o_br_cnt    = br_cnt;
    assign o_taken_cnt = taken_cnt;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_pc_branch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        stall;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        br_less;
    logic        br_equal;
    logic        trap_ack;
    logic        br_un;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        trap;
    logic [31:0] trap_epc;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_br;
    logic [31:0] m_tk;
    bit          m_trap;

    always #5 clk = ~clk;

    pc_branch_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC),
        .CNT_W    (32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (instr_valid),
        .i_stall       (stall),
        .i_is_branch   (is_branch),
        .i_is_jal      (is_jal),
        .i_is_jalr     (is_jalr),
        .i_funct3      (funct3),
        .i_imm         (imm),
        .i_rs1_data    (rs1_data),
        .i_br_less     (br_less),
        .i_br_equal    (br_equal),
        .i_trap_ack    (trap_ack),
        .o_br_un       (br_un),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4),
        .o_taken       (taken),
        .o_trap        (trap),
        .o_trap_epc    (trap_epc),
        .o_br_cnt      (br_cnt),
        .o_taken_cnt   (taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic bit model_cond(input logic [2:0] f3, input bit less, input bit eq);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return less;
            3'd5, 3'd7: return !less;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic idle();
        rst = 0; instr_valid = 1; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        funct3 = 3'd0; imm = 0; rs1_data = 0; br_less = 0; br_equal = 0; trap_ack = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_trap"}, {31'd0, trap}, {31'd0, m_trap});
        check({tag, "_epc"}, trap_epc, m_epc);
        check({tag, "_brcnt"}, br_cnt, m_br);
        check({tag, "_tkcnt"}, taken_cnt, m_tk);
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered state just after the edge.
    task automatic step(input string tag);
        logic [31:0] tgt;
        bit          c;
        bit          tk;
        @(negedge clk);
        c   = model_cond(funct3, br_less, br_equal);
        tgt = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
        tk  = !m_trap && (is_jal || is_jalr || (is_branch && c));
        check({tag, "_brun"}, {31'd0, br_un}, {31'd0, (funct3 == 3'd2 || funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)});
        check({tag, "_taken"}, {31'd0, taken}, {31'd0, tk});
        check({tag, "_plus4"}, pc_plus4, m_pc + 32'd4);
        if (rst) begin
            m_pc = RESET_PC; m_epc = 0; m_br = 0; m_tk = 0; m_trap = 0;
        end else if (m_trap) begin
            if (trap_ack) m_trap = 0;
        end else if (instr_valid && !stall) begin
            if (is_branch && !is_jal && !is_jalr) begin
                m_br = m_br + 1;
                if (c) m_tk = m_tk + 1;
            end
            if (tk && (tgt % 4 != 0)) begin
                m_epc = m_pc; m_pc = TRAP_PC; m_trap = 1;
            end else if (tk) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        check_state(tag);
    endtask

    task automatic go_to(input logic [31:0] addr);
        idle(); is_jalr = 1; rs1_data = addr; imm = 0;
        step("goto");
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        m_pc = RESET_PC; m_epc = 0; m_br = 0; m_tk = 0; m_trap = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_brcnt", br_cnt, 32'd0);
        check("rst_tkcnt", taken_cnt, 32'd0);
        idle();

        // BLTU taken, comparator unsigned
        go_to(32'h40);
        is_branch = 1; funct3 = 3'b110; br_less = 1; imm = 32'd16;
        step("bltu");
        check("bltu_pc", pc, 32'h50);
        check("bltu_cnt", br_cnt, 32'd1);
        check("bltu_tk", taken_cnt, 32'd1);

        // BGE not taken
        idle(); is_branch = 1; funct3 = 3'b101; br_less = 1; imm = 32'd64;
        step("bge");
        check("bge_pc", pc, 32'h54);
        check("bge_cnt", br_cnt, 32'd2);
        check("bge_tk", taken_cnt, 32'd1);

        // JALR clears bit 0
        idle(); is_jalr = 1; rs1_data = 32'h1001; imm = 0;
        step("jalr");
        check("jalr_pc", pc, 32'h1000);

        // Misaligned taken branch traps
        go_to(32'h200);
        is_branch = 1; funct3 = 3'b000; br_equal = 1; imm = 32'd6;
        step("mis");
        check("mis_pc", pc, 32'h100);
        check("mis_epc", trap_epc, 32'h200);
        check("mis_trap", {31'd0, trap}, 32'd1);
        idle(); is_jal = 1; imm = 32'd8;
        repeat (3) step("trap_hold");
        check("trap_hold_pc", pc, 32'h100);
        idle(); trap_ack = 1;
        step("ack");
        check("ack_trap", {31'd0, trap}, 32'd0);
        idle();
        step("after_ack");

        // Stall holds a taken JAL
        idle(); stall = 1; is_jal = 1; imm = 32'h40;
        step("stall");
        check("stall_pc", pc, 32'h104);
        idle(); instr_valid = 0; is_jal = 1; imm = 32'h40;
        step("novalid");

        // Wrap at the top of the address space
        go_to(32'hFFFF_FFFC);
        step("wrap");
        check("wrap_pc", pc, 32'h0);

        // Reset wins mid-trap
        is_jal = 1; imm = 32'd2;
        step("trap2");
        idle(); rst = 1; trap_ack = 0;
        step("rst_trap");
        check("rst_trap_pc", pc, RESET_PC);
        check("rst_trap_st", {31'd0, trap}, 32'd0);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int kind;
            idle();
            rst         = ($urandom_range(0, 63) == 0);
            instr_valid = ($urandom_range(0, 7) != 0);
            stall       = ($urandom_range(0, 5) == 0);
            kind        = $urandom_range(0, 9);
            is_branch   = (kind <= 5);
            is_jal      = (kind == 6 || kind == 7);
            is_jalr     = (kind == 8);
            funct3      = 3'($urandom_range(0, 7));
            br_less     = 1'($urandom_range(0, 1));
            br_equal    = 1'($urandom_range(0, 1));
            trap_ack    = ($urandom_range(0, 3) == 0);
            imm         = $urandom_range(0, 15) == 0 ? ($urandom() & 32'h0000_03FF)
                                                     : (($urandom() & 32'h0000_0FFC) - 32'h800);
            rs1_data    = $urandom_range(0, 7) == 0 ? $urandom() : ($urandom() & 32'hFFFF_FFFD);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
